// File: rtl/pipelined_adder.sv
// -----------------------------------------------------------------------------
// pipelined_adder
//   Parametrised add/subtract unit with the carry chain split into STAGES
//   register stages, each resolving CHUNK = WIDTH/STAGES bits. Valid/ready
//   handshake on both sides; one beat per cycle; latency STAGES cycles.
//
// Ports
//   clk        clock, rising edge
//   rst        asynchronous active-high reset
//   in_valid   operand beat present
//   in_ready   block accepts a beat this cycle
//   a, b       operands (WIDTH)
//   cin        carry-in for add (ignored when sub=1)
//   sub        1: a-b, 0: a+b+cin
//   out_valid  result beat present
//   out_ready  consumer accepts the result
//   sum        result (WIDTH)
//   cout       carry out of the MSB (subtract: 1 = no borrow)
//   ovf        signed two's-complement overflow
//
// Optional build macro
//   PIPELINED_ADDER_SAT_EN  saturate sum on signed overflow in the final stage
// -----------------------------------------------------------------------------
module pipelined_adder #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned CHUNK = WIDTH / STAGES;

    // Single global advance: the whole pipe moves or the whole pipe holds.
    logic advance;

    // Inputs seen by each stage: entry logic for stage 0, previous stage
    // registers for the rest.
    logic             st_v   [STAGES];
    logic [WIDTH-1:0] st_a   [STAGES];
    logic [WIDTH-1:0] st_bx  [STAGES];
    logic [WIDTH-1:0] st_sum [STAGES];
    logic             st_c   [STAGES];

    assign advance  = out_ready | ~out_valid;
    assign in_ready = advance;

    // Subtract is a + ~b + 1.
    assign st_v[0]   = in_valid & advance;
    assign st_a[0]   = a;
    assign st_bx[0]  = sub ? ~b : b;
    assign st_c[0]   = sub | cin;
    assign st_sum[0] = '0;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int unsigned LO = k * CHUNK;

        logic [CHUNK:0]   chunk_res;
        logic [WIDTH-1:0] sum_d;

        always_comb begin
            chunk_res = {1'b0, st_a[k][LO +: CHUNK]}
                      + {1'b0, st_bx[k][LO +: CHUNK]}
                      + {{CHUNK{1'b0}}, st_c[k]};
            sum_d = st_sum[k];
            sum_d[LO +: CHUNK] = chunk_res[CHUNK-1:0];
        end

        if (k < STAGES - 1) begin : g_mid
            logic             valid_q;
            logic             carry_q;
            logic [WIDTH-1:0] a_q;
            logic [WIDTH-1:0] bx_q;
            logic [WIDTH-1:0] sum_q;

            // Data only loads with a real beat; a held bubble keeps old data.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    valid_q <= 1'b0;
                    carry_q <= 1'b0;
                    a_q     <= '0;
                    bx_q    <= '0;
                    sum_q   <= '0;
                end else if (advance) begin
                    valid_q <= st_v[k];
                    if (st_v[k]) begin
                        carry_q <= chunk_res[CHUNK];
                        a_q     <= st_a[k];
                        bx_q    <= st_bx[k];
                        sum_q   <= sum_d;
                    end
                end
            end

            assign st_v[k+1]   = valid_q;
            assign st_c[k+1]   = carry_q;
            assign st_a[k+1]   = a_q;
            assign st_bx[k+1]  = bx_q;
            assign st_sum[k+1] = sum_q;
        end else begin : g_last
            logic             ovf_d;
            logic [WIDTH-1:0] res_d;
            logic             valid_q;
            logic             cout_q;
            logic             ovf_q;
            logic [WIDTH-1:0] sum_q;

            always_comb begin
                ovf_d = (st_a[k][WIDTH-1] == st_bx[k][WIDTH-1])
                      & (sum_d[WIDTH-1] != st_a[k][WIDTH-1]);
`ifdef PIPELINED_ADDER_SAT_EN
                if (ovf_d) begin
                    res_d = st_a[k][WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                             : {1'b0, {(WIDTH-1){1'b1}}};
                end else begin
                    res_d = sum_d;
                end
`else
                res_d = sum_d;
`endif
            end

            // Outputs only change on a real beat, so they are stable under stall.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    valid_q <= 1'b0;
                    cout_q  <= 1'b0;
                    ovf_q   <= 1'b0;
                    sum_q   <= '0;
                end else if (advance) begin
                    valid_q <= st_v[k];
                    if (st_v[k]) begin
                        cout_q <= chunk_res[CHUNK];
                        ovf_q  <= ovf_d;
                        sum_q  <= res_d;
                    end
                end
            end

            assign out_valid = valid_q;
            assign cout      = cout_q;
            assign ovf       = ovf_q;
            assign sum       = sum_q;
        end
    end

endmodule
